// File: rtl/featuremap_accum_relu_pool.sv
// Sums NUM_CH partial maps + bias, saturates, ReLU, then 2x2/2 max-pools the raster stream.
// Latency 4 cycles (3 accumulate + 1 pool); no backpressure, one pixel/cycle accepted always.
module featuremap_accum_relu_pool #(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_BITS  = 16,
  parameter int NUM_CH     = 6,
  parameter int IN_WIDTH   = 10,
  parameter int IN_HEIGHT  = 10,
  parameter int BIAS       = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
  input  logic                           valid_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  output logic                           frame_end
);

  localparam int SW  = DATA_WIDTH + 3;
  localparam int NP  = NUM_CH / 2;
  localparam int LBD = IN_WIDTH / 2;
  localparam int CW  = $clog2(IN_WIDTH);
  localparam int RW  = $clog2(IN_HEIGHT);

  localparam logic signed [SW-1:0] BIAS_EXT = SW'(BIAS);
  localparam logic signed [SW-1:0] SAT_MAX  =
    {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

  if ((IN_WIDTH % 2) != 0 || (IN_HEIGHT % 2) != 0 || (NUM_CH % 2) != 0 ||
      FRAC_BITS >= DATA_WIDTH || IN_WIDTH < 2 || IN_HEIGHT < 2) begin : g_bad_param
    $error("featuremap_accum_relu_pool: unsupported parameter set");
  end

  function automatic logic signed [SW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(SW-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // Accumulate pipeline
  logic                   s1_vld, s2_vld, s3_vld;
  logic signed [SW-1:0]   pair_c [NP];
  logic signed [SW-1:0]   s1_sum [NP];
  logic signed [SW-1:0]   sum_c;
  logic signed [SW-1:0]   s2_sum;
  logic signed [DATA_WIDTH-1:0] s3_dat;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      pair_c[i] = sext(data_in[(2*i)*DATA_WIDTH +: DATA_WIDTH]) +
                  sext(data_in[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    sum_c = BIAS_EXT;
    for (int i = 0; i < NP; i++) begin
      sum_c = sum_c + s1_sum[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      s1_vld <= valid_in;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
    end
  end

  // Negative sums collapse to zero, which covers both negative clipping and ReLU.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      s1_sum[i] <= pair_c[i];
    end
    s2_sum <= sum_c;
    if (s2_sum[SW-1])
      s3_dat <= '0;
    else if (s2_sum > SAT_MAX)
      s3_dat <= SAT_MAX[DATA_WIDTH-1:0];
    else
      s3_dat <= s2_sum[DATA_WIDTH-1:0];
  end

  // Pool stage
  logic [CW-1:0]                col;
  logic [RW-1:0]                row;
  logic signed [DATA_WIDTH-1:0] hold;
  logic signed [DATA_WIDTH-1:0] line_buf [LBD];
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] above;
  logic signed [DATA_WIDTH-1:0] win_max;

  always_comb begin
    pair_max = (hold > s3_dat) ? hold : s3_dat;
    above    = line_buf[col[CW-1:1]];
    win_max  = (above > pair_max) ? above : pair_max;
  end

  always_ff @(posedge clk) begin
    if (s3_vld) begin
      if (!col[0])
        hold <= s3_dat;
      else if (!row[0])
        line_buf[col[CW-1:1]] <= pair_max;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      frame_end <= 1'b0;
      if (s3_vld) begin
        if (col[0] && row[0]) begin
          data_out  <= win_max;
          valid_out <= 1'b1;
          frame_end <= (row == ROW_LAST) && (col == COL_LAST);
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/featuremap_accum_relu_pool.md
Name: featuremap_accum_relu_pool

Overview:
- Downstream stage of a featuremap block in the conv2 layer.
- Takes the per-input-channel partial convolution outputs of one output feature map, sums them with a bias, and applies ReLU.
- Then performs 2x2 stride-2 max pooling on the raster-streamed map.
- Produces a pooled stream (default 10x10 -> 5x5) for the next layer.

Parameters:
- DATA_WIDTH, 24: sample width; signed two's-complement fixed point.
- FRAC_BITS, 16: fractional bits of the fixed-point format. Default format is Q8.16, so 1.0 = 0x010000.
- NUM_CH, 6: number of partial-sum channels summed.
- IN_WIDTH, 10: columns per input row. Must be even.
- IN_HEIGHT, 10: rows per input frame. Must be even.
- BIAS, 0: signed integer; raw fixed-point bias in the same format as the data.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  NUM_CH*DATA_WIDTH  packed channel samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- valid_in  input  1  all channels carry one aligned pixel this cycle.
- data_out  output  DATA_WIDTH  pooled sample.
- valid_out  output  1  data_out valid, one-cycle pulse per pooled pixel.
- frame_end  output  1  asserted together with valid_out on the last pooled pixel of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_out=0, valid_out=0, frame_end=0.
  - Pipeline valid bits, column counter and row counter cleared to 0.
  - Line buffer contents not cleared; they are always written before being read.
- Accumulate stage, 3 registered stages:
  - S1: NUM_CH/2 pairwise sums, sign-extended to DATA_WIDTH+3 bits.
  - S2: sum of the S1 results plus sign-extended BIAS.
  - S3: saturate to DATA_WIDTH signed (clip to 0x7FFFFF / 0x800000 at default width), then ReLU (negative -> 0).
  - Each stage carries a valid bit. No back-pressure; a valid pixel is never dropped.
- Pool stage: consumes S3 outputs only when the S3 valid bit is set.
  - col counter: 0..IN_WIDTH-1. row counter: 0..IN_HEIGHT-1. Both advance only on S3-valid pixels; col wraps and row increments, and row wraps to 0 after the last row of a frame.
  - Even col: hold register <= pixel.
  - Odd col: pair_max = max(hold, pixel), signed compare.
  - Even row, odd col: line_buf[col>>1] <= pair_max. Line buffer depth IN_WIDTH/2.
  - Odd row, odd col: data_out <= max(line_buf[col>>1], pair_max) and valid_out=1 for one cycle.
  - frame_end=1 when this occurs at row=IN_HEIGHT-1, col=IN_WIDTH-1.
  - Otherwise valid_out=0, frame_end=0, and data_out holds its last value.
- Latency: valid_out rises 4 cycles after the valid_in beat that carries the bottom-right pixel of a 2x2 window. That is 3 accumulate stages plus 1 pool register.
- Arbitrary gaps in valid_in are allowed. Results are identical to a gapless stream; only timing shifts.
- Back-to-back frames need no idle cycle; counters wrap seamlessly.
- Ties in max: either operand (values are equal).
- Reset asserted mid-frame: the partial frame is discarded. The first valid_in after release is treated as pixel (0,0). No stale valid_out may appear after release.
- Throughput: one pixel per cycle sustained. Output rate is at most 1/4 of the input rate.

Test Plan:
1. Uniform frame: all 6 channels 0x010000 for 100 pixels, BIAS=0, gapless. Expect 25 valid_out pulses, each data_out=0x060000. First pulse 4 cycles after the 12th valid_in. frame_end only on the 25th pulse.
2. ReLU and bias: all channels 0xFF0000 (-1.0), BIAS=0x020000. Sum is -4.0, so every output = 0x000000. Repeat with BIAS=0x080000: every output = 0x020000.
3. Saturation: all channels 0x7FFFFF -> all outputs 0x7FFFFF. Negative saturation: all channels 0x800000 -> outputs 0 after ReLU.
4. Ramp: channel 0 = (r*10+c)<<16, other channels 0, BIAS=0. Pooled output (i,j) = ((2i+1)*10+(2j+1))<<16; first output 0x0B0000, last 0x630000. Outputs appear in raster order.
5. Gapped stream: the ramp from test 4 with valid_in randomly deasserted about 50% of cycles. Expect the identical 25-value sequence, exactly 25 pulses and 1 frame_end.
6. Reset mid-frame: assert rst for 2 cycles after 37 pixels of a ramp, then send a full ramp frame. Expect no valid_out from the aborted frame after release, then exactly the 25 values from test 4.
